// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues 16-bit command words and issues them one at a time
// to a remote-comm transmitter. After each command it waits for the send to
// complete and then for a response byte. A positive acknowledge moves on to
// the next command. A negative acknowledge, a timeout or an abort ends the
// sequence and reports the first error seen.

module cmd_sequencer #(
  parameter int         DEPTH       = 8,
  parameter int         TMO_CYC     = 1000000,
  parameter logic [7:0] POS_ACK     = 8'hA5,
  parameter bit         STOP_ON_ERR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_cmd,
  input  logic [15:0]              wr_data,
  output logic                     full,
  input  logic                     start,
  input  logic                     abort,
  output logic [15:0]              cmd,
  output logic                     snd_cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   ack_cnt,
  output logic [7:0]               last_resp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NACK  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP
  } state_t;

  state_t         state;
  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [TW-1:0]  timer;

  logic           push;
  logic           resp_take;
  logic           resp_pos;
  logic           tmo_hit;

  // The first error of a sequence is the one reported; later ones only
  // keep err set.
  function automatic logic [1:0] first_err(input logic [1:0] cur,
                                           input logic [1:0] nxt);
    return (cur == ERR_NONE) ? nxt : cur;
  endfunction

  // Pushes are only taken while idle and not full.
  assign push = !rst && (state == IDLE) && wr_cmd && !full;

  // A response counts in WAIT_RESP, or in WAIT_SNT when it arrives in the
  // same cycle as the send-complete indication.
  assign resp_take = ((state == WAIT_RESP) && resp_rdy) ||
                     ((state == WAIT_SNT) && cmd_snt && resp_rdy);
  assign resp_pos  = (resp == POS_ACK);
  assign tmo_hit   = (timer == TW'(TMO_CYC - 1));

  assign full = (count == CW'(DEPTH));
  assign busy = (state != IDLE);
  assign cmd  = (count == '0) ? 16'h0000 : mem[rd_ptr];

  // Queue storage: written on accepted pushes only.
  // NOTE: the storage array has no reset; occupancy and pointers decide
  // which words are valid, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Sequencer FSM with queue pointers, handshake timer and status outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the pre-edge values of state, count and err_code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      timer     <= '0;
      snd_cmd   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      ack_cnt   <= '0;
      last_resp <= 8'h00;
    end else begin
      snd_cmd <= 1'b0;
      done    <= 1'b0;

      if ((state != IDLE) && abort) begin
        // Abort wins over every other event in the same cycle.
        state    <= IDLE;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        timer    <= '0;
        done     <= 1'b1;
        err      <= 1'b1;
        err_code <= first_err(err_code, ERR_ABORT);
      end else if (resp_take) begin
        last_resp <= resp;
        timer     <= '0;
        if (resp_pos) begin
          ack_cnt <= ack_cnt + 1'b1;
        end else begin
          err      <= 1'b1;
          err_code <= first_err(err_code, ERR_NACK);
        end

        if (!resp_pos && STOP_ON_ERR) begin
          // Negative ack halts the sequence and drops what is left.
          state  <= IDLE;
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
          done   <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= SEND;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + 1'b1;
            end
            if (start) begin
              err      <= 1'b0;
              err_code <= ERR_NONE;
              if (count != '0) begin
                state   <= SEND;
                ack_cnt <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end

          SEND: begin
            // The strobe is registered, so it is high during the first
            // WAIT_SNT cycle while cmd still shows the head word.
            snd_cmd <= 1'b1;
            state   <= WAIT_SNT;
            timer   <= '0;
          end

          WAIT_SNT: begin
            if (cmd_snt) begin
              state <= WAIT_RESP;
              timer <= '0;
            end else if (tmo_hit) begin
              state    <= IDLE;
              rd_ptr   <= '0;
              wr_ptr   <= '0;
              count    <= '0;
              timer    <= '0;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= first_err(err_code, ERR_TMO);
            end else begin
              timer <= timer + 1'b1;
            end
          end

          WAIT_RESP: begin
            if (tmo_hit) begin
              state    <= IDLE;
              rd_ptr   <= '0;
              wr_ptr   <= '0;
              count    <= '0;
              timer    <= '0;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= first_err(err_code, ERR_TMO);
            end else begin
              timer <= timer + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
